// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one block-wide main memory between icache (read-only)
// and dcache (read/write-back), one requester granted at a time.
// Ports:
//   clock, reset        - clock and async active-low reset
//   d_read/d_write      - dcache block requests, d_address/d_writedata in
//   d_readdata          - registered block returned to dcache
//   d_busywait          - dcache stall
//   i_read, i_address   - icache block request
//   i_readdata          - registered block returned to icache
//   i_busywait          - icache stall
//   mem_read/mem_write  - memory strobes, mem_address/mem_writedata out
//   mem_readdata        - memory read block in
//   mem_busywait        - memory busy in
module mem_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32,
    parameter int RR_EN  = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [DATA_W-1:0] d_writedata,
    output logic [DATA_W-1:0] d_readdata,
    output logic              d_busywait,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [DATA_W-1:0] i_readdata,
    output logic              i_busywait,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata,
    input  logic              mem_busywait
);

    typedef enum logic [2:0] {
        IDLE,
        SERVE_D,
        SERVE_I,
        DONE_D,
        DONE_I
    } state_t;

    state_t            state_q;
    logic              issued_q;
    logic              last_i_q;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic [DATA_W-1:0] i_rdata_q;

    logic d_req;
    logic i_req;
    logic grant_d;
    logic grant_i;
    logic serve_d;
    logic serve_i;

    assign d_req = d_read | d_write;
    assign i_req = i_read;

    // On contention, round-robin hands the grant to whoever did not win last.
    assign grant_d = d_req & (~i_req | (RR_EN == 0) | last_i_q);
    assign grant_i = i_req & ~grant_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            issued_q  <= 1'b0;
            last_i_q  <= 1'b1;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            d_rdata_q <= '0;
            i_rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_d) begin
                        state_q  <= SERVE_D;
                        last_i_q <= 1'b0;
                        wr_q     <= d_write;
                        addr_q   <= d_address;
                        wdata_q  <= d_write ? d_writedata : '0;
                    end else if (grant_i) begin
                        state_q  <= SERVE_I;
                        last_i_q <= 1'b1;
                        wr_q     <= 1'b0;
                        addr_q   <= i_address;
                        wdata_q  <= '0;
                    end
                end
                SERVE_D: begin
                    // The memory has not seen the strobe yet in the first cycle.
                    if (!issued_q) begin
                        issued_q <= 1'b1;
                    end else if (!mem_busywait) begin
                        issued_q <= 1'b0;
                        state_q  <= DONE_D;
                        if (!wr_q) begin
                            d_rdata_q <= mem_readdata;
                        end
                    end
                end
                SERVE_I: begin
                    if (!issued_q) begin
                        issued_q <= 1'b1;
                    end else if (!mem_busywait) begin
                        issued_q  <= 1'b0;
                        state_q   <= DONE_I;
                        i_rdata_q <= mem_readdata;
                    end
                end
                DONE_D:  state_q <= IDLE;
                DONE_I:  state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign serve_d = (state_q == SERVE_D);
    assign serve_i = (state_q == SERVE_I);

    assign mem_read      = (serve_d & ~wr_q) | serve_i;
    assign mem_write     = serve_d & wr_q;
    assign mem_address   = (serve_d | serve_i) ? addr_q : '0;
    assign mem_writedata = serve_d ? wdata_q : '0;

    assign d_readdata = d_rdata_q;
    assign i_readdata = i_rdata_q;

    // Gated by reset so every output reads 0 while reset is held.
    assign d_busywait = reset & d_req & (state_q != DONE_D);
    assign i_busywait = reset & i_req & (state_q != DONE_I);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random checks of mem_arbiter against a
// transaction-level model (grant order, latency, shadow memory contents).
module tb_mem_arbiter;

    localparam bit RR = 1'b1;

    logic        clock;
    logic        reset;
    logic        d_read, d_write;
    logic [5:0]  d_address;
    logic [31:0] d_writedata, d_readdata;
    logic        d_busywait;
    logic        i_read;
    logic [5:0]  i_address;
    logic [31:0] i_readdata;
    logic        i_busywait;
    logic        mem_read, mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata, mem_readdata;
    logic        mem_busywait;

    logic        f_d_read, f_d_write;
    logic [5:0]  f_d_address;
    logic [31:0] f_d_writedata, f_d_readdata;
    logic        f_d_busywait;
    logic        f_i_read;
    logic [5:0]  f_i_address;
    logic [31:0] f_i_readdata;
    logic        f_i_busywait;
    logic        f_mem_read, f_mem_write;
    logic [5:0]  f_mem_address;
    logic [31:0] f_mem_writedata, f_mem_readdata;
    logic        f_mem_busywait;

    mem_arbiter #(.ADDR_W(6), .DATA_W(32), .RR_EN(1)) u_rr (
        .clock(clock), .reset(reset),
        .d_read(d_read), .d_write(d_write),
        .d_address(d_address), .d_writedata(d_writedata),
        .d_readdata(d_readdata), .d_busywait(d_busywait),
        .i_read(i_read), .i_address(i_address),
        .i_readdata(i_readdata), .i_busywait(i_busywait),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_writedata(mem_writedata),
        .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
    );

    mem_arbiter #(.ADDR_W(6), .DATA_W(32), .RR_EN(0)) u_fp (
        .clock(clock), .reset(reset),
        .d_read(f_d_read), .d_write(f_d_write),
        .d_address(f_d_address), .d_writedata(f_d_writedata),
        .d_readdata(f_d_readdata), .d_busywait(f_d_busywait),
        .i_read(f_i_read), .i_address(f_i_address),
        .i_readdata(f_i_readdata), .i_busywait(f_i_busywait),
        .mem_read(f_mem_read), .mem_write(f_mem_write),
        .mem_address(f_mem_address), .mem_writedata(f_mem_writedata),
        .mem_readdata(f_mem_readdata), .mem_busywait(f_mem_busywait)
    );

    assign f_mem_busywait = 1'b0;
    assign f_mem_readdata = 32'h0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Memory device: busy for mem_n cycles of each access, then ready.
    logic [31:0] devmem [64];
    int  mem_n  = 1;
    bit  stuck  = 0;
    int  rem    = 0;
    bit  active = 0;

    assign mem_readdata = devmem[mem_address];

    initial mem_busywait = 1'b0;
    always @(posedge clock) begin
        #2;
        if (mem_read || mem_write) begin
            if (!active) begin
                active = 1;
                rem = mem_n;
            end
            if (stuck) begin
                mem_busywait = 1'b1;
            end else if (rem > 0) begin
                mem_busywait = 1'b1;
                rem--;
            end else begin
                mem_busywait = 1'b0;
                if (mem_write) devmem[mem_address] = mem_writedata;
            end
        end else begin
            active = 0;
            mem_busywait = 1'b0;
        end
    end

    // Reference model state
    logic [31:0] shadow [64];
    bit          last_i_m;
    logic [31:0] ld_m, li_m;
    bit          sq [$];

    task automatic model_reset();
        last_i_m = 1'b1;
        ld_m = 32'h0;
        li_m = 32'h0;
    endtask

    task automatic txn(input bit dq, input bit dr, input bit dw,
                       input logic [5:0] da, input logic [31:0] dd,
                       input bit iq, input logic [5:0] ia,
                       input int n, input string tag);
        bit first_i, side, ddone, idone;
        logic [31:0] dexp, iexp;
        int t_d, t_i, cyc;
        mem_n = n;
        dexp = ld_m;
        iexp = li_m;
        if (dq && iq) first_i = RR ? !last_i_m : 1'b0;
        else first_i = iq;
        for (int k = 0; k < 2; k++) begin
            side = (k == 0) ? first_i : !first_i;
            if (!side && dq) begin
                if (dw) shadow[da] = dd;
                else ld_m = shadow[da];
                dexp = ld_m;
                last_i_m = 1'b0;
            end else if (side && iq) begin
                li_m = shadow[ia];
                iexp = li_m;
                last_i_m = 1'b1;
            end
        end
        t_d = (dq && iq && first_i) ? 2 * n + 5 : n + 2;
        t_i = (dq && iq && !first_i) ? 2 * n + 5 : n + 2;
        sq.delete();
        @(negedge clock);
        d_read = dq & dr;
        d_write = dq & dw;
        d_address = da;
        d_writedata = dd;
        i_read = iq;
        i_address = ia;
        cyc = 0;
        ddone = !dq;
        idone = !iq;
        while (!(ddone && idone) && cyc < 100) begin
            #1;
            sq.push_back(mem_read | mem_write);
            if (cyc == 0) begin
                check({tag, "_dbw0"}, d_busywait, dq);
                check({tag, "_ibw0"}, i_busywait, iq);
            end
            if (cyc == 1) begin
                check({tag, "_addr"}, mem_address, first_i ? ia : da);
                check({tag, "_strb"}, {mem_read, mem_write},
                      (!first_i && dw) ? 2'b01 : 2'b10);
                if (!first_i && dw) check({tag, "_wdat"}, mem_writedata, dd);
                if (!iq) check({tag, "_iidle"}, i_busywait, 0);
            end
            if (!ddone && !d_busywait) begin
                ddone = 1;
                check({tag, "_dlat"}, cyc, t_d);
                check({tag, "_drd"}, d_readdata, dexp);
                d_read = 0;
                d_write = 0;
            end
            if (!idone && !i_busywait) begin
                idone = 1;
                check({tag, "_ilat"}, cyc, t_i);
                check({tag, "_ird"}, i_readdata, iexp);
                i_read = 0;
            end
            if (!(ddone && idone)) begin
                @(negedge clock);
                cyc++;
            end
        end
        check({tag, "_done"}, ddone && idone, 1);
    endtask

    initial begin
        bit s, prev, fs, fprev, exp_i;
        int cyc, g, fg, n;
        logic [1:0] mode;

        for (int a = 0; a < 64; a++) begin
            devmem[a] = $urandom;
            shadow[a] = devmem[a];
        end
        devmem[6'h15] = 32'hDEADBEEF;
        shadow[6'h15] = 32'hDEADBEEF;
        model_reset();

        reset = 0;
        d_read = 0; d_write = 0; d_address = 0; d_writedata = 0;
        i_read = 0; i_address = 0;
        f_d_read = 0; f_d_write = 0; f_d_address = 0; f_d_writedata = 0;
        f_i_read = 0; f_i_address = 0;
        repeat (2) @(negedge clock);
        #1;
        check("rst_strb", {mem_read, mem_write}, 0);
        check("rst_addr", mem_address, 0);
        check("rst_rd", {d_readdata, i_readdata} != 0, 0);
        reset = 1;

        // dcache read, 4 busy cycles
        txn(1, 1, 0, 6'h15, 0, 0, 0, 4, "dread");
        check("dread_val", d_readdata, 32'hDEADBEEF);

        // dcache write-back leaves d_readdata alone
        txn(1, 0, 1, 6'h2A, 32'h0BADF00D, 0, 0, 3, "dwrite");
        check("dwrite_mem", devmem[6'h2A], 32'h0BADF00D);

        // Reset during a stalled SERVE_D
        stuck = 1;
        @(negedge clock);
        d_read = 1;
        d_address = 6'h07;
        repeat (20) @(negedge clock);
        #1;
        check("stuck_serve", {mem_read, mem_address}, {1'b1, 6'h07});
        reset = 0;
        #1;
        check("mid_rst_strb", {mem_read, mem_write}, 0);
        check("mid_rst_addr", mem_address, 0);
        check("mid_rst_dbw", d_busywait, 0);
        check("mid_rst_drd", d_readdata, 0);
        d_read = 0;
        stuck = 0;
        model_reset();
        @(negedge clock);
        reset = 1;

        // Simultaneous requests straight from reset: D then I
        txn(1, 1, 0, 6'h15, 0, 1, 6'h09, 2, "both");
        // DONE_D and the following IDLE both keep strobes low
        check("gap_pre", sq[3], 1);
        check("gap_0", sq[4], 0);
        check("gap_1", sq[5], 0);
        check("gap_post", sq[6], 1);

        // icache changes its inputs after the grant
        mem_n = 2;
        @(negedge clock);
        i_read = 1;
        i_address = 6'h33;
        @(negedge clock);
        #1;
        check("iwd_addr", mem_address, 6'h33);
        i_read = 0;
        i_address = 6'h0C;
        #1;
        check("iwd_ibw", i_busywait, 0);
        cyc = 0;
        while (mem_read && cyc < 50) begin
            check("iwd_hold", mem_address, 6'h33);
            @(negedge clock);
            #1;
            cyc++;
        end
        check("iwd_end", mem_read, 0);
        li_m = shadow[6'h33];
        last_i_m = 1'b1;
        check("iwd_ird", i_readdata, li_m);
        @(negedge clock);
        #1;
        check("iwd_idle", {mem_read, mem_write}, 0);

        // Continuous contention: RR alternates, fixed priority starves I
        mem_n = 1;
        @(negedge clock);
        d_read = 1; d_address = 6'h01;
        i_read = 1; i_address = 6'h02;
        f_d_read = 1; f_d_address = 6'h05;
        f_i_read = 1; f_i_address = 6'h06;
        g = 0; fg = 0; prev = 0; fprev = 0; cyc = 0;
        while ((g < 6 || fg < 6) && cyc < 200) begin
            #1;
            s = mem_read | mem_write;
            fs = f_mem_read | f_mem_write;
            if (s && !prev && g < 6) begin
                exp_i = !last_i_m;
                last_i_m = exp_i;
                check("rr_grant", mem_address, exp_i ? 6'h02 : 6'h01);
                g++;
                if (g == 6) begin
                    d_read = 0;
                    i_read = 0;
                end
            end
            if (fs && !fprev && fg < 6) begin
                check("fp_grant", f_mem_address, 6'h05);
                fg++;
                if (fg == 6) begin
                    f_d_read = 0;
                    f_i_read = 0;
                end
            end
            if (fg < 6) check("fp_ibw", f_i_busywait, 1);
            prev = s;
            fprev = fs;
            @(negedge clock);
            cyc++;
        end
        check("contend_done", g + fg, 12);
        repeat (6) @(negedge clock);
        ld_m = shadow[6'h01];
        li_m = shadow[6'h02];
        check("contend_idle", {mem_read, mem_write, f_mem_read, f_mem_write}, 0);

        // Random traffic on a small address range
        for (int t = 0; t < 40; t++) begin
            mode = 2'($urandom_range(1, 3));
            n = $urandom_range(1, 4);
            case ($urandom_range(0, 2))
                0: txn(mode[0] | mode[1], mode != 2'd2, mode[1],
                       6'($urandom_range(0, 7)), $urandom,
                       1, 6'($urandom_range(0, 7)), n, "rnd");
                1: txn(1, mode != 2'd2, mode[1],
                       6'($urandom_range(0, 7)), $urandom,
                       0, 0, n, "rnd");
                default: txn(0, 0, 0, 0, 0,
                             1, 6'($urandom_range(0, 7)), n, "rnd");
            endcase
        end
        for (int a = 0; a < 8; a++) check("rnd_mem", devmem[a], shadow[a]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
